// File: rtl/supernova_mem_arb_pkg.sv
// Shared types and helpers for the L1-to-memory arbiter
// and the round-robin picker it uses.
package supernova_mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_MEM,
        RESP
    } state_t;

    localparam int DEF_NUM_REQ = 4;
    localparam int ID_BITS     = $clog2(DEF_NUM_REQ);

    function automatic int unsigned popcount(input logic [7:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < 8; i++) begin
            n = n + 32'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/supernova_mem_arbiter_if.sv
// Requester-side and memory-side bus of the arbiter,
// plus its status and performance outputs.
interface supernova_mem_arbiter_if #(
    parameter int NUM_REQ        = 4,
    parameter int LINE_SIZE      = 64,
    parameter int PHYS_ADDR_SIZE = 56
);
    localparam int IDW = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]                req_valid;
    logic [NUM_REQ-1:0]                req_we;
    logic [NUM_REQ*PHYS_ADDR_SIZE-1:0] req_addr;
    logic [NUM_REQ*LINE_SIZE-1:0]      req_wdata;
    logic [NUM_REQ-1:0]                req_ack;
    logic                              req_err;
    logic [LINE_SIZE-1:0]              req_rdata;

    logic                              mem_req;
    logic                              mem_we;
    logic [PHYS_ADDR_SIZE-1:0]         mem_addr;
    logic [LINE_SIZE-1:0]              mem_wdata;
    logic [LINE_SIZE-1:0]              mem_rdata;
    logic                              mem_ack;

    logic                              busy;
    logic [IDW-1:0]                    grant_id;
    logic [31:0]                       grant_count;
    logic [31:0]                       contention_count;
    logic [31:0]                       timeout_count;

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        input  mem_rdata, mem_ack,
        output req_ack, req_err, req_rdata,
        output mem_req, mem_we, mem_addr, mem_wdata,
        output busy, grant_id,
        output grant_count, contention_count, timeout_count
    );

    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        output mem_rdata, mem_ack,
        input  req_ack, req_err, req_rdata,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        input  busy, grant_id,
        input  grant_count, contention_count, timeout_count
    );

endinterface

// File: rtl/supernova_rr_pick.sv
// Round-robin picker: first valid index at or after
// rr_ptr, wrapping modulo N.
module supernova_rr_pick
    import supernova_mem_arb_pkg::*;
#(
    parameter int N   = DEF_NUM_REQ,
    parameter int IDW = ID_BITS
) (
    input  logic [N-1:0]   i_req_valid,
    input  logic [IDW-1:0] i_rr_ptr,
    output logic           o_any_valid,
    output logic [IDW-1:0] o_pick
);

    logic [IDW-1:0] w_idx;

    always_comb begin
        w_idx       = '0;
        o_any_valid = |i_req_valid;
        o_pick      = i_rr_ptr;
        // Walk from the far end so the closest candidate wins.
        for (int k = N - 1; k >= 0; k--) begin
            w_idx = IDW'((int'(i_rr_ptr) + k) % N);
            if (i_req_valid[w_idx]) begin
                o_pick = w_idx;
            end
        end
    end

endmodule

// File: rtl/supernova_mem_arbiter.sv
// Round-robin arbiter sharing one line-wide memory port
// between L1 requesters; one transaction in flight.
module supernova_mem_arbiter
    import supernova_mem_arb_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int LINE_SIZE      = 64,
    parameter int PHYS_ADDR_SIZE = 56,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input logic                    clk,
    input logic                    rst_n,
    supernova_mem_arbiter_if.slave bus
);

    localparam int IDW = $clog2(NUM_REQ);
    localparam int WDW = $clog2(TIMEOUT_CYCLES);

    state_t                    r_state;
    state_t                    w_state_nxt;
    logic [IDW-1:0]            r_rr_ptr;
    logic [WDW-1:0]            r_wdog;
    logic                      r_mem_req;
    logic                      r_mem_we;
    logic [PHYS_ADDR_SIZE-1:0] r_mem_addr;
    logic [LINE_SIZE-1:0]      r_mem_wdata;
    logic [NUM_REQ-1:0]        r_req_ack;
    logic                      r_req_err;
    logic [LINE_SIZE-1:0]      r_rdata;
    logic                      r_busy;
    logic [IDW-1:0]            r_grant_id;
    logic [31:0]               r_grant_cnt;
    logic [31:0]               r_cont_cnt;
    logic [31:0]               r_tout_cnt;

    logic                      w_any;
    logic [IDW-1:0]            w_pick;
    logic                      w_grant;
    logic                      w_done;
    logic                      w_tout;
    logic                      w_tick;
    logic                      w_close;

    supernova_rr_pick #(
        .N   (NUM_REQ),
        .IDW (IDW)
    ) u_pick (
        .i_req_valid (bus.req_valid),
        .i_rr_ptr    (r_rr_ptr),
        .o_any_valid (w_any),
        .o_pick      (w_pick)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        w_done      = 1'b0;
        w_tout      = 1'b0;
        w_tick      = 1'b0;
        w_close     = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_grant     = 1'b1;
                    w_state_nxt = WAIT_MEM;
                end
            end
            WAIT_MEM: begin
                // A mem_ack on the watchdog's last cycle still counts.
                if (bus.mem_ack) begin
                    w_done      = 1'b1;
                    w_state_nxt = RESP;
                end else if (r_wdog == WDW'(TIMEOUT_CYCLES - 1)) begin
                    w_tout      = 1'b1;
                    w_state_nxt = RESP;
                end else begin
                    w_tick = 1'b1;
                end
            end
            RESP: begin
                w_close     = 1'b1;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_rr_ptr    <= '0;
            r_wdog      <= '0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_req_ack   <= '0;
            r_req_err   <= 1'b0;
            r_rdata     <= '0;
            r_busy      <= 1'b0;
            r_grant_id  <= '0;
            r_grant_cnt <= '0;
            r_cont_cnt  <= '0;
            r_tout_cnt  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_grant) begin
                r_mem_req   <= 1'b1;
                r_busy      <= 1'b1;
                r_grant_id  <= w_pick;
                r_mem_we    <= bus.req_we[w_pick];
                r_mem_addr  <= bus.req_addr[w_pick*PHYS_ADDR_SIZE +: PHYS_ADDR_SIZE];
                r_mem_wdata <= bus.req_wdata[w_pick*LINE_SIZE +: LINE_SIZE];
                r_rr_ptr    <= (int'(w_pick) == NUM_REQ - 1) ? '0 : w_pick + 1'b1;
                r_grant_cnt <= r_grant_cnt + 32'd1;
                r_wdog      <= '0;
                if (popcount(8'(bus.req_valid)) >= 2) begin
                    r_cont_cnt <= r_cont_cnt + 32'd1;
                end
            end
            if (w_tick) begin
                r_wdog <= r_wdog + 1'b1;
            end
            if (w_done || w_tout) begin
                r_mem_req <= 1'b0;
                r_req_ack <= NUM_REQ'(1) << r_grant_id;
                r_req_err <= w_tout;
            end
            if (w_done) begin
                r_rdata <= bus.mem_rdata;
            end
            if (w_tout) begin
                r_tout_cnt <= r_tout_cnt + 32'd1;
            end
            if (w_close) begin
                r_req_ack <= '0;
                r_req_err <= 1'b0;
                r_busy    <= 1'b0;
            end
        end
    end

    assign bus.req_ack          = r_req_ack;
    assign bus.req_err          = r_req_err;
    assign bus.req_rdata        = r_rdata;
    assign bus.mem_req          = r_mem_req;
    assign bus.mem_we           = r_mem_we;
    assign bus.mem_addr         = r_mem_addr;
    assign bus.mem_wdata        = r_mem_wdata;
    assign bus.busy             = r_busy;
    assign bus.grant_id         = r_grant_id;
    assign bus.grant_count      = r_grant_cnt;
    assign bus.contention_count = r_cont_cnt;
    assign bus.timeout_count    = r_tout_cnt;

endmodule

// File: tb/tb_supernova_mem_arbiter.sv
// Bench for supernova_mem_arbiter: directed scenarios with literal
// expectations, then random traffic against a transaction-level model.
module tb_supernova_mem_arbiter;

    localparam int N  = 4;
    localparam int LW = 64;
    localparam int AW = 56;
    localparam int T  = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    supernova_mem_arbiter_if #(
        .NUM_REQ(N), .LINE_SIZE(LW), .PHYS_ADDR_SIZE(AW)
    ) bus ();

    supernova_mem_arbiter #(
        .NUM_REQ(N), .LINE_SIZE(LW), .PHYS_ADDR_SIZE(AW), .TIMEOUT_CYCLES(T)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // stimulus state
    logic [N-1:0]  d_valid, d_we;
    logic [AW-1:0] d_addr  [N];
    logic [LW-1:0] d_wdata [N];
    logic          d_mack;
    logic [LW-1:0] d_mrdata;

    // reference model
    logic [N-1:0]  e_ack;
    logic          e_err, e_busy, e_mreq, e_mwe;
    logic [AW-1:0] e_maddr;
    logic [LW-1:0] e_mwdata, e_rdata;
    logic [1:0]    e_gid;
    logic [31:0]   e_gc, e_cc, e_tc;
    int            m_rr, m_wait;

    int n_pass, n_tot;
    bit rand_mode;
    logic [N-1:0] drop;
    int mem_open, mem_cnt, mem_lat;
    int got[$];
    int exp_order[5] = '{0, 1, 2, 3, 0};

    task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
        n_tot++;
        if (a === e) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, a, e, $time);
    endtask

    task automatic clear_drivers();
        d_valid = '0; d_we = '0; d_mack = 1'b0; d_mrdata = '0;
        for (int i = 0; i < N; i++) begin
            d_addr[i] = '0; d_wdata[i] = '0;
        end
        drop = '0; mem_open = 0; mem_cnt = 0; mem_lat = 0;
    endtask

    task automatic drive_bus();
        bus.req_valid = d_valid;
        bus.req_we    = d_we;
        for (int i = 0; i < N; i++) begin
            bus.req_addr[i*AW +: AW]  = d_addr[i];
            bus.req_wdata[i*LW +: LW] = d_wdata[i];
        end
        bus.mem_ack   = d_mack;
        bus.mem_rdata = d_mrdata;
    endtask

    task automatic model_reset();
        e_ack = '0; e_err = 0; e_busy = 0; e_mreq = 0; e_mwe = 0;
        e_maddr = '0; e_mwdata = '0; e_rdata = '0; e_gid = '0;
        e_gc = 0; e_cc = 0; e_tc = 0; m_rr = 0; m_wait = 0;
    endtask

    // One clock of the arbiter seen as transactions: respond, wait, or grant.
    task automatic model_step();
        int pc, pk;
        if (e_ack != '0) begin
            e_ack = '0; e_err = 0; e_busy = 0;
        end else if (e_mreq) begin
            if (d_mack) begin
                e_mreq = 0; e_err = 0; e_rdata = d_mrdata;
                e_ack[e_gid] = 1'b1;
            end else if (m_wait == T - 1) begin
                e_mreq = 0; e_err = 1; e_tc = e_tc + 1;
                e_ack[e_gid] = 1'b1;
            end else begin
                m_wait++;
            end
        end else begin
            pc = 0; pk = -1;
            for (int k = 0; k < N; k++) begin
                if (d_valid[k]) pc++;
                if (pk < 0 && d_valid[(m_rr + k) % N]) pk = (m_rr + k) % N;
            end
            if (pk >= 0) begin
                e_mreq = 1; e_busy = 1; e_gid = 2'(pk);
                e_mwe = d_we[pk]; e_maddr = d_addr[pk]; e_mwdata = d_wdata[pk];
                m_rr = (pk + 1) % N; m_wait = 0;
                e_gc = e_gc + 1;
                if (pc >= 2) e_cc = e_cc + 1;
            end
        end
    endtask

    task automatic compare_all();
        chk("req_ack", bus.req_ack, e_ack);
        chk("req_err", bus.req_err, e_err);
        chk("req_rdata", bus.req_rdata, e_rdata);
        chk("mem_req", bus.mem_req, e_mreq);
        chk("mem_we", bus.mem_we, e_mwe);
        chk("mem_addr", bus.mem_addr, e_maddr);
        chk("mem_wdata", bus.mem_wdata, e_mwdata);
        chk("busy", bus.busy, e_busy);
        chk("grant_id", bus.grant_id, e_gid);
        chk("grant_count", bus.grant_count, e_gc);
        chk("contention_count", bus.contention_count, e_cc);
        chk("timeout_count", bus.timeout_count, e_tc);
    endtask

    task automatic new_payload(input int i);
        d_we[i]    = 1'($urandom_range(0, 1));
        d_addr[i]  = AW'({$urandom, $urandom});
        d_wdata[i] = {$urandom, $urandom};
    endtask

    // Requesters and a memory with random latency 0..10 (>7 times out).
    task automatic gen();
        for (int i = 0; i < N; i++) begin
            if (drop[i]) begin
                d_valid[i] = 1'b0; drop[i] = 1'b0;
            end else if (d_valid[i] && bus.req_ack[i]) begin
                drop[i] = 1'b1;
            end else if (!d_valid[i]) begin
                if ($urandom_range(0, 2) == 0) begin
                    d_valid[i] = 1'b1; new_payload(i);
                end
            end else if ($urandom_range(0, 3) == 0) begin
                new_payload(i);
            end
        end
        d_mack = 1'b0;
        d_mrdata = {$urandom, $urandom};
        if (mem_open != 0) begin
            if (mem_cnt == mem_lat) begin
                d_mack = 1'b1; mem_open = 0;
            end else begin
                mem_cnt++;
            end
        end else if (bus.mem_req) begin
            mem_lat = $urandom_range(0, 10);
            if (mem_lat == 0) d_mack = 1'b1;
            else begin
                mem_open = 1; mem_cnt = 1;
            end
        end else if ($urandom_range(0, 15) == 0) begin
            d_mack = 1'b1;
        end
    endtask

    task automatic step();
        drive_bus();
        if (rst_n) model_step();
        @(posedge clk);
        @(negedge clk);
        compare_all();
        if (rand_mode) gen();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_drivers();
        model_reset();
        drive_bus();
        @(negedge clk);
        compare_all();
        rst_n = 1'b1;
    endtask

    initial begin
        n_pass = 0; n_tot = 0; rand_mode = 0;
        clear_drivers();
        model_reset();
        drive_bus();
        repeat (2) @(negedge clk);
        compare_all();
        chk("rst_mem_req", bus.mem_req, 0);
        chk("rst_grant_count", bus.grant_count, 0);
        rst_n = 1'b1;

        // all four requesting continuously, memory acks in first wait cycle
        d_valid = '1;
        for (int i = 0; i < N; i++) d_addr[i] = AW'(i * 'h100);
        for (int c = 0; c < 40 && got.size() < 5; c++) begin
            step();
            d_mack = bus.mem_req;
            if (bus.mem_req) got.push_back(int'(bus.grant_id));
        end
        chk("A_grants_seen", 64'(got.size()), 5);
        for (int k = 0; k < got.size() && k < 5; k++)
            chk("A_order", 64'(got[k]), 64'(exp_order[k]));
        chk("A_contention", bus.contention_count, 5);

        // single read from requester 1, ack at cycle 5
        do_reset();
        d_valid[1] = 1'b1; d_addr[1] = 56'h1000; d_we[1] = 1'b0;
        step();
        chk("B_mreq_c1", bus.mem_req, 1);
        chk("B_addr", bus.mem_addr, 64'h1000);
        chk("B_gid", bus.grant_id, 1);
        repeat (4) step();
        chk("B_mreq_c5", bus.mem_req, 1);
        d_mack = 1'b1; d_mrdata = {16{4'hA}};
        step();
        d_mack = 1'b0; d_mrdata = '0;
        chk("B_ack", bus.req_ack, 4'b0010);
        chk("B_rdata", bus.req_rdata, {16{4'hA}});
        chk("B_mreq_c6", bus.mem_req, 0);
        chk("B_gc", bus.grant_count, 1);
        chk("B_cc", bus.contention_count, 0);
        step();
        d_valid[1] = 1'b0;
        chk("B_busy_c7", bus.busy, 0);
        step();

        // writeback from requester 2 that never gets an ack
        d_valid[2] = 1'b1; d_we[2] = 1'b1;
        d_addr[2] = 56'h2000; d_wdata[2] = {16{4'h5}};
        step();
        chk("C_we", bus.mem_we, 1);
        d_wdata[2] = 64'h0123_4567_89ab_cdef;
        repeat (3) step();
        chk("C_wdata_hold", bus.mem_wdata, {16{4'h5}});
        repeat (4) step();
        chk("C_mreq_c8", bus.mem_req, 1);
        step();
        chk("C_mreq_c9", bus.mem_req, 0);
        chk("C_ack", bus.req_ack, 4'b0100);
        chk("C_err", bus.req_err, 1);
        chk("C_tc", bus.timeout_count, 1);
        d_mack = 1'b1; d_mrdata = '1;
        step();
        d_valid[2] = 1'b0;
        chk("C_busy", bus.busy, 0);
        step();
        d_mack = 1'b0;
        chk("C_rdata_kept", bus.req_rdata, {16{4'hA}});

        // ack on the watchdog's final cycle
        d_valid[0] = 1'b1; d_we[0] = 1'b0; d_addr[0] = 56'h3000;
        step();
        chk("D_gid", bus.grant_id, 0);
        repeat (7) step();
        chk("D_mreq_last", bus.mem_req, 1);
        d_mack = 1'b1; d_mrdata = 64'hdead_beef_cafe_f00d;
        step();
        d_mack = 1'b0;
        chk("D_ack", bus.req_ack, 4'b0001);
        chk("D_err", bus.req_err, 0);
        chk("D_tc", bus.timeout_count, 1);
        chk("D_rdata", bus.req_rdata, 64'hdead_beef_cafe_f00d);
        step();
        d_valid[0] = 1'b0;
        step();

        // asynchronous reset in the middle of a wait
        d_valid[3] = 1'b1;
        step();
        step();
        #2 rst_n = 1'b0;
        #1;
        chk("E_mreq", bus.mem_req, 0);
        chk("E_busy", bus.busy, 0);
        chk("E_gid", bus.grant_id, 0);
        chk("E_gc", bus.grant_count, 0);
        chk("E_tc", bus.timeout_count, 0);
        clear_drivers();
        model_reset();
        drive_bus();
        @(negedge clk);
        compare_all();
        rst_n = 1'b1;
        d_valid = 4'b1010;
        step();
        chk("E_pick", bus.grant_id, 1);
        chk("E_cc", bus.contention_count, 1);
        d_mack = 1'b1;
        step();
        d_mack = 1'b0;
        chk("E_ack", bus.req_ack, 4'b0010);
        step();
        d_valid = '0;
        step();

        // random traffic
        rand_mode = 1;
        gen();
        repeat (3000) step();

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
